// File: rtl/baopoco_pkg.sv
// rtl/baopoco_pkg.sv - shared types and defaults for the accumulation controller
package baopoco_pkg;

  localparam int VEC_LEN_DEF = 2048;
  localparam int CH_W_DEF    = 11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_ACCUM     = 2'd2
  } state_e;

  // A zero length would never wrap the spectrum counter; run it as one spectrum.
  function automatic logic [31:0] len_eff(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/baopoco_acc_ctrl_if.sv
// rtl/baopoco_acc_ctrl_if.sv - control/sample-stream bundle around the accumulation controller
interface baopoco_acc_ctrl_if;
  logic        arm;
  logic [31:0] acc_len;
  logic        sync_in;
  logic        vld_in;
  logic        vld_out;
  logic        first_out;
  logic        last_out;
  logic        dump;
  logic        abort;
  logic        sync_out;
  logic [31:0] acc_cnt;
  logic        armed;

  modport master (
    output arm, acc_len, sync_in, vld_in,
    input  vld_out, first_out, last_out, dump, abort, sync_out, acc_cnt, armed
  );

  modport slave (
    input  arm, acc_len, sync_in, vld_in,
    output vld_out, first_out, last_out, dump, abort, sync_out, acc_cnt, armed
  );
endinterface

// File: rtl/baopoco_acc_cnt.sv
// rtl/baopoco_acc_cnt.sv - channel/spectrum counters and integration length shadow
module baopoco_acc_cnt
  import baopoco_pkg::*;
#(
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int CH_W    = CH_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,      // counting this cycle (ACCUM, or the sync that enters it)
  input  logic        sync,
  input  logic        vld,
  input  logic [31:0] acc_len,
  output logic        samp_first,  // flags describe the sample presented this cycle
  output logic        samp_last,
  output logic        samp_dump,
  output logic        abort_hit    // sync cut a partially counted integration
);

  logic [CH_W-1:0] ch_q, ch_d;
  logic [31:0]     sp_q, sp_d;
  logic [31:0]     len_q, len_d;

  logic            dump_pos;
  logic            restart;
  logic [CH_W-1:0] ch_e;
  logic [31:0]     sp_e;
  logic [31:0]     len_e;
  logic            ch_wrap;
  logic            sp_wrap;

  // Counter view for this cycle. A sync on the dump sample lets the natural wrap
  // finish the integration, so the following sample is channel 0 of the next one.
  always_comb begin
    dump_pos   = (ch_q == CH_W'(VEC_LEN - 1)) && (sp_q == len_q - 32'd1);
    restart    = sync && !(vld && dump_pos);
    ch_e       = restart ? '0 : ch_q;
    sp_e       = restart ? '0 : sp_q;
    len_e      = restart ? len_eff(acc_len) : len_q;
    ch_wrap    = (ch_e == CH_W'(VEC_LEN - 1));
    sp_wrap    = (sp_e == len_e - 32'd1);
    samp_first = (sp_e == 32'd0);
    samp_last  = sp_wrap;
    samp_dump  = ch_wrap && sp_wrap;
    abort_hit  = restart && ((ch_q != '0) || (sp_q != 32'd0));
  end

  // Next counter state: advance on each valid sample, re-latch length at integration end.
  always_comb begin
    ch_d  = ch_q;
    sp_d  = sp_q;
    len_d = len_q;
    if (active) begin
      ch_d  = ch_e;
      sp_d  = sp_e;
      len_d = len_e;
      if (vld) begin
        ch_d = ch_e + CH_W'(1);
        if (ch_wrap) begin
          if (sp_wrap) begin
            sp_d  = 32'd0;
            len_d = len_eff(acc_len);
          end else begin
            sp_d = sp_e + 32'd1;
          end
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      sp_q  <= 32'd0;
      len_q <= 32'd1;
    end else begin
      ch_q  <= ch_d;
      sp_q  <= sp_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/baopoco_acc_ctrl.sv
// rtl/baopoco_acc_ctrl.sv - arm/sync FSM and registered accumulator control outputs
module baopoco_acc_ctrl
  import baopoco_pkg::*;
#(
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int CH_W    = CH_W_DEF
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        arm,
  input  logic [31:0] acc_len,
  input  logic        sync_in,
  input  logic        vld_in,
  output logic        vld_out,
  output logic        first_out,
  output logic        last_out,
  output logic        dump,
  output logic        abort,
  output logic        sync_out,
  output logic [31:0] acc_cnt,
  output logic        armed
);

  state_e      state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        vld_out_q, vld_out_d;
  logic        sync_out_q, sync_out_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        dump_q, dump_d;
  logic        abort_q, abort_d;
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic        armed_q, armed_d;

  logic        rst_ok;
  logic        active;
  logic        take;
  logic        samp_first, samp_last, samp_dump, abort_hit;

  assign rst_ok = rst_sync_q[1];
  assign active = (state_q == ST_ACCUM) || ((state_q == ST_WAIT_SYNC) && sync_in);
  assign take   = active && vld_in;

  baopoco_acc_cnt #(.VEC_LEN(VEC_LEN), .CH_W(CH_W)) u_cnt (
    .clk        (user_clk),
    .rst_n      (user_rst_n),
    .active     (active),
    .sync       (sync_in),
    .vld        (vld_in),
    .acc_len    (acc_len),
    .samp_first (samp_first),
    .samp_last  (samp_last),
    .samp_dump  (samp_dump),
    .abort_hit  (abort_hit)
  );

  // Reset release shifts through two flops before the FSM may accept arm.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Next-state logic: ACCUM is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (arm && rst_ok) state_d = ST_WAIT_SYNC;
      ST_WAIT_SYNC: if (sync_in) state_d = ST_ACCUM;
      ST_ACCUM:     state_d = ST_ACCUM;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output values for the sample seen this cycle, presented one cycle later.
  always_comb begin
    vld_out_d  = vld_in;
    sync_out_d = sync_in;
    first_d    = take && samp_first;
    last_d     = take && samp_last;
    dump_d     = take && samp_dump;
    abort_d    = (state_q == ST_ACCUM) && abort_hit;
    acc_cnt_d  = acc_cnt_q + {31'd0, take && samp_dump};
    armed_d    = (state_d != ST_IDLE);
  end

  // All state and output registers share the asynchronous reset.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= ST_IDLE;
      rst_sync_q <= 2'b00;
      vld_out_q  <= 1'b0;
      sync_out_q <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      dump_q     <= 1'b0;
      abort_q    <= 1'b0;
      acc_cnt_q  <= 32'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_sync_q <= rst_sync_d;
      vld_out_q  <= vld_out_d;
      sync_out_q <= sync_out_d;
      first_q    <= first_d;
      last_q     <= last_d;
      dump_q     <= dump_d;
      abort_q    <= abort_d;
      acc_cnt_q  <= acc_cnt_d;
      armed_q    <= armed_d;
    end
  end

  assign vld_out   = vld_out_q;
  assign sync_out  = sync_out_q;
  assign first_out = first_q;
  assign last_out  = last_q;
  assign dump      = dump_q;
  assign abort     = abort_q;
  assign acc_cnt   = acc_cnt_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_baopoco_acc_ctrl.sv
// tb/tb_baopoco_acc_ctrl.sv - self-checking bench for baopoco_acc_ctrl
module tb_baopoco_acc_ctrl;

  localparam int V = 4;

  logic user_clk;
  logic user_rst_n;
  baopoco_acc_ctrl_if bus ();

  baopoco_acc_ctrl #(.VEC_LEN(V), .CH_W(2)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .arm        (bus.arm),
    .acc_len    (bus.acc_len),
    .sync_in    (bus.sync_in),
    .vld_in     (bus.vld_in),
    .vld_out    (bus.vld_out),
    .first_out  (bus.first_out),
    .last_out   (bus.last_out),
    .dump       (bus.dump),
    .abort      (bus.abort),
    .sync_out   (bus.sync_out),
    .acc_cnt    (bus.acc_cnt),
    .armed      (bus.armed)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position of the sample inside its integration.
  int          m_mode;   // 0 idle, 1 waiting for sync, 2 integrating
  longint      m_pos;
  longint      m_len;
  logic [31:0] m_cnt;
  int          m_edges;
  logic [6:0]  exp_v;    // {vld, sync, first, last, dump, abort, armed}
  logic [6:0]  act_v;

  function automatic longint eff(input logic [31:0] l);
    return (l == 32'd0) ? 1 : longint'(l);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_len = 1; m_cnt = 32'd0; m_edges = 0;
  endtask

  task automatic model_step(input logic a, input logic s, input logic v, input logic [31:0] l);
    logic f, la, d, ab, ok, at_end;
    longint total;
    f = 0; la = 0; d = 0; ab = 0;
    ok = (m_edges >= 2);
    if (m_edges < 10) m_edges++;
    if (m_mode == 2 || (m_mode == 1 && s)) begin
      total  = m_len * V;
      at_end = (m_mode == 2) && v && (m_pos == total - 1);
      if (s && !at_end) begin
        if (m_mode == 2 && m_pos != 0) ab = 1;
        m_pos = 0;
        m_len = eff(l);
      end
      if (v) begin
        total = m_len * V;
        f  = (m_pos < V);
        la = (m_pos >= total - V);
        d  = (m_pos == total - 1);
        m_pos++;
        if (m_pos == total) begin
          m_pos = 0;
          m_cnt = m_cnt + 32'd1;
          m_len = eff(l);
        end
      end
      m_mode = 2;
    end else if (m_mode == 0 && a && ok) begin
      m_mode = 1;
    end
    exp_v = {v, s, f, la, d, ab, (m_mode != 0)};
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic drive(input logic a, input logic s, input logic v, input logic [31:0] l);
    bus.arm = a; bus.sync_in = s; bus.vld_in = v; bus.acc_len = l;
    model_step(a, s, v, l);
    @(posedge user_clk);
    #1;
    act_v = {bus.vld_out, bus.sync_out, bus.first_out, bus.last_out, bus.dump, bus.abort, bus.armed};
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    #2;
    user_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic start(input logic [31:0] l);
    do_reset();
    repeat (3) drive(0, 0, 0, l);
    drive(1, 0, 0, l);
    drive(0, 1, 0, l);
  endtask

  task automatic test_reset();
    bus.arm = 0; bus.sync_in = 0; bus.vld_in = 0; bus.acc_len = 32'd0;
    user_rst_n = 1'b0;
    #12;
    act_v = {bus.vld_out, bus.sync_out, bus.first_out, bus.last_out, bus.dump, bus.abort, bus.armed};
    n_cmp++;
    if (act_v !== 7'd0 || bus.acc_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: outputs=%b acc_cnt=%0d, required 0000000 / 0", act_v, bus.acc_cnt);
    end
    @(posedge user_clk);
    #1;
    user_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int dumps = 0;
    start(32'd3);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 32'd3);
      n_cmp++;
      if (act_v !== exp_v || act_v[4] !== (i < 4) || act_v[3] !== (i >= 8) || act_v[2] !== (i == 11)) begin
        n_bad++;
        $display("FAIL basic sample %0d: outputs=%b, required %b", i, act_v, exp_v);
      end
      dumps += act_v[2];
    end
    n_cmp++;
    if (bus.acc_cnt !== 32'd1 || dumps != 1) begin
      n_bad++;
      $display("FAIL basic_count: acc_cnt=%0d dumps=%0d, required 1 / 1", bus.acc_cnt, dumps);
    end
  endtask

  task automatic test_zero_len();
    start(32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 32'd0);
      n_cmp++;
      if (act_v !== exp_v || act_v[4:3] !== 2'b11 || act_v[2] !== (i == 3 || i == 7)) begin
        n_bad++;
        $display("FAIL zero_len sample %0d: outputs=%b, required %b", i, act_v, exp_v);
      end
    end
    n_cmp++;
    if (bus.acc_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL zero_len_count: acc_cnt=%0d, required 2", bus.acc_cnt);
    end
  endtask

  task automatic test_abort();
    int aborts = 0;
    start(32'd2);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 32'd2);
    drive(0, 1, 0, 32'd2);
    aborts += act_v[1];
    drive(0, 0, 0, 32'd2);
    aborts += act_v[1];
    drive(0, 0, 1, 32'd2);
    n_cmp++;
    if (aborts != 1 || bus.acc_cnt !== 32'd0 || act_v[4] !== 1'b1 || act_v !== exp_v) begin
      n_bad++;
      $display("FAIL abort: aborts=%0d acc_cnt=%0d outputs=%b, required 1 / 0 / %b", aborts, bus.acc_cnt, act_v, exp_v);
    end
  endtask

  task automatic test_len_change();
    int d0 = -1;
    int d1 = -1;
    logic [31:0] l = 32'd2;
    start(l);
    for (int i = 0; i < 28; i++) begin
      if (i == 3) l = 32'd5;
      drive(0, 0, 1, l);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL len_change sample %0d: outputs=%b, required %b", i, act_v, exp_v);
      end
      if (act_v[2]) begin
        if (d0 < 0) d0 = i; else d1 = i;
      end
    end
    n_cmp++;
    if (d0 != 7 || d1 != 27 || bus.acc_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL len_change_dumps: at %0d,%0d acc_cnt=%0d, required 7,27 / 2", d0, d1, bus.acc_cnt);
    end
  endtask

  task automatic test_coincident();
    start(32'd1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'd1);
    drive(0, 1, 1, 32'd1);
    n_cmp++;
    if (act_v[2:1] !== 2'b10 || bus.acc_cnt !== 32'd1 || act_v !== exp_v) begin
      n_bad++;
      $display("FAIL coincident: dump/abort=%b acc_cnt=%0d, required 10 / 1", act_v[2:1], bus.acc_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'd1);
      n_cmp++;
      if (act_v !== exp_v || act_v[4] !== 1'b1 || act_v[2] !== (i == 3)) begin
        n_bad++;
        $display("FAIL coincident_next %0d: outputs=%b, required %b", i, act_v, exp_v);
      end
    end
    n_cmp++;
    if (bus.acc_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL coincident_count: acc_cnt=%0d, required 2", bus.acc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start(32'd0);
    for (int i = 0; i < 30; i++) drive(0, 0, 1, 32'd0);
    n_cmp++;
    if (bus.acc_cnt !== 32'd7) begin
      n_bad++;
      $display("FAIL reset_mid_pre: acc_cnt=%0d, required 7", bus.acc_cnt);
    end
    bus.vld_in = 1'b1;
    user_rst_n = 1'b0;
    #1;
    act_v = {bus.vld_out, bus.sync_out, bus.first_out, bus.last_out, bus.dump, bus.abort, bus.armed};
    n_cmp++;
    if (act_v !== 7'd0 || bus.acc_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async: outputs=%b acc_cnt=%0d, required 0000000 / 0", act_v, bus.acc_cnt);
    end
    #1;
    user_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, (i == 2), 1, 32'd0);
      n_cmp++;
      if (act_v !== exp_v || act_v[4] !== 1'b0 || act_v[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_after %0d: outputs=%b, required %b", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] l = 32'd2;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 30) == 0) l = $urandom_range(0, 3);
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), l);
      n_cmp++;
      if (act_v !== exp_v || bus.acc_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL random cycle %0d: outputs=%b acc_cnt=%0d, required %b / %0d", i, act_v, bus.acc_cnt, exp_v, m_cnt);
      end
    end
  endtask

  initial begin
    user_rst_n = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_zero_len();
    test_abort();
    test_len_change();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
